// File: rtl/target_spawner_if.sv
// Signal bundle between the target spawner and its neighbours (game control, random generator,
// renderer, score display). The spawner uses the slave modport.
interface target_spawner_if;
    logic       start;
    logic       stop;
    logic       hit;
    logic [7:0] random_in;
    logic       trigger;
    logic [6:0] target_x;
    logic [5:0] target_y;
    logic       target_valid;
    logic [7:0] score;
    logic [7:0] miss_count;
    logic       busy;

    modport master (
        output start, stop, hit, random_in,
        input  trigger, target_x, target_y, target_valid, score, miss_count, busy
    );

    modport slave (
        input  start, stop, hit, random_in,
        output trigger, target_x, target_y, target_valid, score, miss_count, busy
    );
endinterface

// File: rtl/target_spawner.sv
// Requests random values, maps them to a target position, times the target's life and scores it.
// Optional macro SPAWN_AVOID_REPEAT_EN: re-roll spawns that land on top of the previous target.
module target_spawner #(
    parameter int unsigned SCREEN_W = 96,
    parameter int unsigned SCREEN_H = 64,
    parameter int unsigned TGT_SIZE = 8,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned LIFETIME = 6250000,
    parameter int unsigned GAP      = 625000
) (
    input logic              CLOCK,
    input logic              reset,
    target_spawner_if.slave  bus
);
    localparam int unsigned ModX = SCREEN_W - TGT_SIZE + 1;
    localparam int unsigned ModY = SCREEN_H - TGT_SIZE + 1;

    typedef enum logic [3:0] {
        StIdle, StReqX, StWaitX, StCapX, StReqY, StWaitY, StCapY, StActive, StGap
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        trig_q, trig_d;
    logic [6:0]  x_cap_q, x_cap_d;
    logic [6:0]  tx_q, tx_d;
    logic [5:0]  ty_q, ty_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  miss_q, miss_d;
    logic [5:0]  y_new;
    logic        accept;

    assign y_new = 6'(bus.random_in % ModY);

`ifdef SPAWN_AVOID_REPEAT_EN
    logic [1:0] retry_q, retry_d;
    logic [6:0] dx;
    logic [5:0] dy;

    always_comb begin
        dx     = (x_cap_q >= tx_q) ? x_cap_q - tx_q : tx_q - x_cap_q;
        dy     = (y_new >= ty_q) ? y_new - ty_q : ty_q - y_new;
        // The fourth candidate is taken no matter where it lands.
        accept = !((32'(dx) < TGT_SIZE) && (32'(dy) < TGT_SIZE)) || (retry_q == 2'd3);
    end
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        x_cap_d = x_cap_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        score_d = score_q;
        miss_d  = miss_q;
`ifdef SPAWN_AVOID_REPEAT_EN
        retry_d = retry_q;
`endif
        if (bus.stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
`ifdef SPAWN_AVOID_REPEAT_EN
                    retry_d = 2'd0;
`endif
                    if (bus.start) state_d = StReqX;
                end
                StReqX, StReqY: begin
                    trig_d  = ~trig_q;
                    cnt_d   = SETTLE - 1;
                    state_d = (state_q == StReqX) ? StWaitX : StWaitY;
                end
                StWaitX, StWaitY: begin
                    if (cnt_q == 32'd0) state_d = (state_q == StWaitX) ? StCapX : StCapY;
                    else cnt_d = cnt_q - 32'd1;
                end
                StCapX: begin
                    x_cap_d = 7'(bus.random_in % ModX);
                    state_d = StReqY;
                end
                StCapY: begin
                    if (accept) begin
                        tx_d    = x_cap_q;
                        ty_d    = y_new;
                        cnt_d   = LIFETIME - 1;
                        state_d = StActive;
`ifdef SPAWN_AVOID_REPEAT_EN
                        retry_d = 2'd0;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = StReqX;
`endif
                    end
                end
                StActive: begin
                    if (bus.hit) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        cnt_d   = GAP - 1;
                        state_d = StGap;
                    end else if (cnt_q == 32'd0) begin
                        if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                        cnt_d   = GAP - 1;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == 32'd0) state_d = StReqX;
                    else cnt_d = cnt_q - 32'd1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            trig_q  <= 1'b0;
            x_cap_q <= 7'd0;
            tx_q    <= 7'd0;
            ty_q    <= 6'd0;
            score_q <= 8'd0;
            miss_q  <= 8'd0;
`ifdef SPAWN_AVOID_REPEAT_EN
            retry_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            x_cap_q <= x_cap_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            score_q <= score_d;
            miss_q  <= miss_d;
`ifdef SPAWN_AVOID_REPEAT_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign bus.trigger      = trig_q;
    assign bus.target_x     = tx_q;
    assign bus.target_y     = ty_q;
    assign bus.target_valid = (state_q == StActive);
    assign bus.score        = score_q;
    assign bus.miss_count   = miss_q;
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_target_spawner.sv
// Bench for target_spawner: directed scenarios plus random stimulus, all checked every cycle
// against a spawn-timeline model (request/capture offsets, lifetime and gap counts).
module tb_target_spawner;
    localparam int LIFE   = 20;
    localparam int GAPC   = 5;
    localparam int SETTLE = 2;
    localparam int CAPX   = SETTLE + 1;
    localparam int REQY   = SETTLE + 2;
    localparam int CAPY   = 2 * SETTLE + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    target_spawner_if bus();

    target_spawner #(.LIFETIME(LIFE), .GAP(GAPC), .SETTLE(SETTLE)) dut (
        .CLOCK (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int tog     = 0;
    logic last_trig = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 spawning (t = cycles since request of x), 2 active, 3 gap.
    int m_mode = 0, m_t = 0, m_age = 0, m_trig = 0, m_cx = 0, m_tx = 0, m_ty = 0;
    int m_score = 0, m_miss = 0, m_retry = 0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    always @(posedge clk) begin
        int cy;
        bit acc;
        if (rst) begin
            m_mode = 0; m_t = 0; m_age = 0; m_trig = 0; m_cx = 0; m_tx = 0; m_ty = 0;
            m_score = 0; m_miss = 0; m_retry = 0;
        end else if (bus.stop) begin
            m_mode = 0; m_retry = 0;
        end else begin
            case (m_mode)
                0: if (bus.start) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (m_t == 0 || m_t == REQY) m_trig ^= 1;
                    if (m_t == CAPX) m_cx = int'(bus.random_in) % 89;
                    if (m_t == CAPY) begin
                        cy  = int'(bus.random_in) % 57;
                        acc = 1'b1;
`ifdef SPAWN_AVOID_REPEAT_EN
                        if (absd(m_cx, m_tx) < 8 && absd(cy, m_ty) < 8 && m_retry < 3) acc = 1'b0;
`endif
                        if (acc) begin
                            m_tx = m_cx; m_ty = cy; m_mode = 2; m_age = 0; m_retry = 0;
                        end else begin
                            m_retry++; m_t = 0;
                        end
                    end else begin
                        m_t++;
                    end
                end
                2: begin
                    if (bus.hit) begin
                        if (m_score < 255) m_score++;
                        m_mode = 3; m_age = 0;
                    end else if (m_age == LIFE - 1) begin
                        if (m_miss < 255) m_miss++;
                        m_mode = 3; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    if (m_age == GAPC - 1) begin m_mode = 1; m_t = 0; end
                    else m_age++;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus.trigger !== last_trig) tog++;
        last_trig = bus.trigger;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("trigger", bus.trigger, m_trig);
            check("target_x", bus.target_x, m_tx);
            check("target_y", bus.target_y, m_ty);
            check("target_valid", bus.target_valid, (m_mode == 2) ? 1 : 0);
            check("score", bus.score, m_score);
            check("miss_count", bus.miss_count, m_miss);
            check("busy", bus.busy, (m_mode != 0) ? 1 : 0);
        end
    end

    task automatic wait_valid(input int budget);
        int n = 0;
        while (bus.target_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.target_valid !== 1'b1) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.hit = 1'b0; bus.random_in = 8'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_score", bus.score, 0);
        check("rst_miss", bus.miss_count, 0);
        check("rst_valid", bus.target_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_trigger", bus.trigger, 0);
        rst = 1'b0;

        // Start and capture: x = 100 % 89, y = 70 % 57.
        @(negedge clk);
        tog = 0; bus.start = 1'b1; bus.random_in = 8'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.random_in = 8'd70;
        repeat (3) @(negedge clk);
        check("valid_before_edge8", bus.target_valid, 0);
        @(negedge clk);
        check("valid_at_edge8", bus.target_valid, 1);
        check("start_x", bus.target_x, 11);
        check("start_y", bus.target_y, 13);
        check("start_toggles", tog, 2);

        // Hit in the 5th active cycle.
        repeat (4) @(negedge clk);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        check("hit_score", bus.score, 1);
        check("hit_miss", bus.miss_count, 0);
        check("hit_valid_low", bus.target_valid, 0);

        // Timeout: valid for exactly LIFE cycles.
        wait_valid(100);
        check("respawn_x", bus.target_x, 70);
        check("respawn_y", bus.target_y, 13);
        cnt = 0;
        while (bus.target_valid === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, 20);
        check("timeout_miss", bus.miss_count, 1);
        check("timeout_gap_busy", bus.busy, 1);

        // Hit on the final active cycle.
        wait_valid(100);
        repeat (19) @(negedge clk);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        check("last_hit_score", bus.score, 2);
        check("last_hit_miss", bus.miss_count, 1);

        // Stop beats hit.
        wait_valid(100);
        bus.stop = 1'b1; bus.hit = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.hit = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.target_valid, 0);
        check("abort_score", bus.score, 2);

        // Reset while waiting for y.
        pulse_start();
        repeat (5) @(negedge clk);
        check("waity_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_score", bus.score, 0);
        check("rst_mid_miss", bus.miss_count, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_x", bus.target_x, 0);
        check("rst_mid_trig", bus.trigger, 0);

        // Saturation after 260 hits.
        pulse_start();
        for (int i = 0; i < 260; i++) begin
            wait_valid(300);
            bus.hit = 1'b1;
            bus.random_in = 8'($urandom_range(1, 127));
            @(negedge clk);
            bus.hit = 1'b0;
        end
        check("sat_score", bus.score, 255);
        check("sat_miss", bus.miss_count, 0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;

`ifdef SPAWN_AVOID_REPEAT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.random_in = 8'd100;
        pulse_start();
        wait_valid(100);
        check("avoid_first_x", bus.target_x, 11);
        check("avoid_first_y", bus.target_y, 43);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        tog = 0;
        wait_valid(300);
        check("avoid_toggles", tog, 8);
        check("avoid_x", bus.target_x, 11);
        check("avoid_y", bus.target_y, 43);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 199) == 0);
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.stop      = ($urandom_range(0, 59) == 0);
            bus.hit       = bus.target_valid ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 19) == 0);
            bus.random_in = 8'($urandom_range(1, 127));
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.hit = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
